// File: rtl/alu_issue_queue_if.sv
// Handshake and status bundle between an operation producer, the issue queue
// and the downstream single-cycle ALU stage.
interface alu_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [9:0]      in_op;
    logic            hold;
    logic [9:0]      ctrl;
    logic            issue_valid;
    logic            rslt_valid;
    logic [TAGW-1:0] rslt_tag;
    logic [CW-1:0]   count;
    logic [7:0]      illegal_cnt;

    modport master (
        output in_valid, in_op, hold,
        input  in_ready, ctrl, issue_valid, rslt_valid, rslt_tag, count, illegal_cnt
    );

    modport slave (
        input  in_valid, in_op, hold,
        output in_ready, ctrl, issue_valid, rslt_valid, rslt_tag, count, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_queue.sv
// In-order issue queue for a single-cycle ALU: filters illegal op codes, tags
// accepted ops, issues one per cycle and tracks the tag of the result in flight.
`ifndef OP_ADD
`define OP_ADD 2'b00
`endif
`ifndef OP_SUB
`define OP_SUB 2'b01
`endif
`ifndef OP_SHIFT
`define OP_SHIFT 2'b10
`endif

module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_queue_if.slave  q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAGW + 10;

    // Entry layout: {tag, op}; the array has no reset so it maps onto RAM.
    logic [EW-1:0]   mem [DEPTH];

    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [TAGW-1:0] tag_reg;
    logic [TAGW-1:0] iss_tag_reg;
    logic [TAGW-1:0] rslt_tag_reg;
    logic [9:0]      ctrl_reg;
    logic            issue_valid_reg;
    logic            rslt_valid_reg;
    logic [7:0]      ill_reg;

    logic            in_ready;
    logic            push;
    logic            op_legal;
    logic            push_legal;
    logic            push_illegal;
    logic            issue;

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign in_ready     = (count_reg < CW'(DEPTH));
    assign push         = q.in_valid && in_ready;
    assign op_legal     = (q.in_op[1:0] == `OP_ADD) || (q.in_op[1:0] == `OP_SUB) ||
                          (q.in_op[1:0] == `OP_SHIFT);
    assign push_legal   = push && op_legal;
    assign push_illegal = push && !op_legal;
    assign issue        = !q.hold && (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        case ({push_legal, issue})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && push_legal) begin
            mem[tail_reg] <= {tag_reg, q.in_op};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            tag_reg         <= '0;
            iss_tag_reg     <= '0;
            rslt_tag_reg    <= '0;
            ctrl_reg        <= '0;
            issue_valid_reg <= 1'b0;
            rslt_valid_reg  <= 1'b0;
            ill_reg         <= '0;
        end else begin
            count_reg <= count_next;
            if (push_legal) begin
                tail_reg <= tail_reg + PW'(1);
                tag_reg  <= tag_reg + TAGW'(1);
            end
            if (push_illegal && (ill_reg != 8'hff)) begin
                ill_reg <= ill_reg + 8'd1;
            end
            // ctrl keeps its last value when nothing issues; only the strobe drops.
            if (issue) begin
                {iss_tag_reg, ctrl_reg} <= mem[head_reg];
                head_reg                <= head_reg + PW'(1);
            end
            issue_valid_reg <= issue;
            rslt_valid_reg  <= issue_valid_reg;
            rslt_tag_reg    <= iss_tag_reg;
        end
    end

    assign q.in_ready    = in_ready;
    assign q.ctrl        = ctrl_reg;
    assign q.issue_valid = issue_valid_reg;
    assign q.rslt_valid  = rslt_valid_reg;
    assign q.rslt_tag    = rslt_tag_reg;
    assign q.count       = count_reg;
    assign q.illegal_cnt = ill_reg;
endmodule
